// File: rtl/wb_serial_bridge_pkg.sv
// rtl/wb_serial_bridge_pkg.sv - shared state type and byte codes for the serial-to-Wishbone bridge
package wb_serial_bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_e;

  localparam int unsigned DEFAULT_TIMEOUT = 1024;
  localparam logic [7:0]  CMD_READ        = 8'h52;
  localparam logic [7:0]  CMD_WRITE       = 8'h57;
  localparam logic [7:0]  RSP_ACK         = 8'h06;
  localparam logic [7:0]  RSP_NAK         = 8'h15;

endpackage

// File: rtl/wb_serial_bridge_if.sv
// rtl/wb_serial_bridge_if.sv - Wishbone-style single-word bus between the bridge and the arbiter
interface wb_serial_bridge_if;

  logic [31:0] adr_o;
  logic [31:0] dat_o;
  logic [31:0] dat_i;
  logic        we_o;
  logic [3:0]  sel_o;
  logic        cyc_o;
  logic        stb_o;
  logic        ack_i;

  modport master (
    output adr_o, dat_o, we_o, sel_o, cyc_o, stb_o,
    input  dat_i, ack_i
  );

  modport slave (
    input  adr_o, dat_o, we_o, sel_o, cyc_o, stb_o,
    output dat_i, ack_i
  );

endinterface

// File: rtl/wb_serial_bridge.sv
// rtl/wb_serial_bridge.sv - byte-stream command parser that issues one Wishbone word access per command
module wb_serial_bridge #(
  parameter int unsigned TIMEOUT   = wb_serial_bridge_pkg::DEFAULT_TIMEOUT,
  parameter logic [7:0]  CMD_READ  = wb_serial_bridge_pkg::CMD_READ,
  parameter logic [7:0]  CMD_WRITE = wb_serial_bridge_pkg::CMD_WRITE
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [7:0]         rx_data,
  input  logic               rx_valid,
  output logic [7:0]         tx_data,
  output logic               tx_valid,
  input  logic               tx_ready,
  output logic               busy,
  output logic               overrun,
  wb_serial_bridge_if.master wb
);
  import wb_serial_bridge_pkg::*;

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  state_e        state_q, state_d;
  logic          is_wr_q, is_wr_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [23:0]   shift_q, shift_d;
  logic [29:0]   adr_q, adr_d;
  logic [31:0]   dat_q, dat_d;
  logic [23:0]   resp_q, resp_d;
  logic          cyc_q, cyc_d;
  logic          we_q, we_d;
  logic          tx_valid_q, tx_valid_d;
  logic [7:0]    tx_data_q, tx_data_d;
  logic          overrun_q, overrun_d;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      is_wr_q    <= 1'b0;
      cnt_q      <= '0;
      tmo_q      <= '0;
      shift_q    <= '0;
      adr_q      <= '0;
      dat_q      <= '0;
      resp_q     <= '0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      overrun_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      is_wr_q    <= is_wr_d;
      cnt_q      <= cnt_d;
      tmo_q      <= tmo_d;
      shift_q    <= shift_d;
      adr_q      <= adr_d;
      dat_q      <= dat_d;
      resp_q     <= resp_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      tx_valid_q <= tx_valid_d;
      tx_data_q  <= tx_data_d;
      overrun_q  <= overrun_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    is_wr_d    = is_wr_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    shift_d    = shift_q;
    adr_d      = adr_q;
    dat_d      = dat_q;
    resp_d     = resp_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    tx_valid_d = tx_valid_q;
    tx_data_d  = tx_data_q;
    overrun_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid && (rx_data == CMD_READ || rx_data == CMD_WRITE)) begin
          is_wr_d = (rx_data == CMD_WRITE);
          cnt_d   = '0;
          state_d = ST_ADDR;
        end
      end

      // The first three bytes collect in shift_q; the address only updates
      // once complete, so adr_o never shows a partial or unaligned value.
      ST_ADDR: begin
        if (rx_valid) begin
          shift_d = {shift_q[15:0], rx_data};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            adr_d = {shift_q, rx_data[7:2]};
            if (is_wr_q) begin
              state_d = ST_DATA;
            end else begin
              state_d = ST_BUS;
              cyc_d   = 1'b1;
              we_d    = 1'b0;
              tmo_d   = '0;
            end
          end
        end
      end

      ST_DATA: begin
        if (rx_valid) begin
          shift_d = {shift_q[15:0], rx_data};
          cnt_d   = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            dat_d   = {shift_q, rx_data};
            state_d = ST_BUS;
            cyc_d   = 1'b1;
            we_d    = 1'b1;
            tmo_d   = '0;
          end
        end
      end

      // ack wins over an expiring timeout in the same cycle.
      ST_BUS: begin
        overrun_d = rx_valid;
        if (wb.ack_i) begin
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          state_d    = ST_RESP;
          tx_valid_d = 1'b1;
          if (is_wr_q) begin
            tx_data_d = RSP_ACK;
            cnt_d     = 2'd0;
          end else begin
            tx_data_d = wb.dat_i[31:24];
            resp_d    = wb.dat_i[23:0];
            cnt_d     = 2'd3;
          end
        end else if (tmo_q == TMO_LAST) begin
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          state_d    = ST_RESP;
          tx_valid_d = 1'b1;
          tx_data_d  = RSP_NAK;
          cnt_d      = 2'd0;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end

      // cnt_q counts the bytes still to send after the one on tx_data.
      ST_RESP: begin
        overrun_d = rx_valid;
        if (tx_ready) begin
          if (cnt_q == 2'd0) begin
            tx_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            tx_data_d = resp_q[23:16];
            resp_d    = {resp_q[15:0], 8'h00};
            cnt_d     = cnt_q - 2'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign wb.adr_o = {adr_q, 2'b00};
  assign wb.dat_o = dat_q;
  assign wb.we_o  = we_q;
  assign wb.cyc_o = cyc_q;
  assign wb.stb_o = cyc_q;
  assign wb.sel_o = {4{cyc_q}};

  assign tx_data  = tx_data_q;
  assign tx_valid = tx_valid_q;
  assign overrun  = overrun_q;
  assign busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_wb_serial_bridge.sv
// tb/tb_wb_serial_bridge.sv - self-checking bench for wb_serial_bridge against a command-level model
module tb_wb_serial_bridge;

  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       rst_i = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic       busy;
  logic       overrun;

  wb_serial_bridge_if bus();

  wb_serial_bridge #(.TIMEOUT(TMO)) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .busy     (busy),
    .overrun  (overrun),
    .wb       (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Command-level model outputs
  logic [31:0] exp_adr = '0;
  logic [31:0] exp_dat = '0;
  logic        exp_we = 1'b0;
  int          exp_len = -1;
  logic [7:0]  exp_tx[$];

  // Slave and host behaviour knobs
  int          ack_lat = -1;
  logic [31:0] slave_data = '0;
  bit          tx_rand = 1'b0;

  // Observations
  logic [7:0]  got_tx[$];
  int          run = 0, k = 0, last_len = 0, cyc_starts = 0, ov_cnt = 0;
  logic [31:0] last_adr = '0, last_dat = '0;
  logic        last_we = 1'b0;
  logic        prev_pend = 1'b0, prev_ov = 1'b0;
  logic [7:0]  prev_data = '0;

  task automatic model_cmd(input logic [7:0] b[$], input int lat, input logic [31:0] rd,
                           input bit abort);
    int i = 0;
    logic [31:0] a;
    while (i < b.size() && b[i] != 8'h52 && b[i] != 8'h57) i++;
    exp_we  = (b[i] == 8'h57);
    a       = {b[i+1], b[i+2], b[i+3], b[i+4]};
    exp_adr = a & 32'hFFFF_FFFC;
    if (exp_we) exp_dat = {b[i+5], b[i+6], b[i+7], b[i+8]};
    ack_lat    = lat;
    slave_data = rd;
    if (abort) begin
      exp_len = -1;
      return;
    end
    if (lat >= 0 && lat < TMO) begin
      exp_len = lat + 1;
      if (exp_we) exp_tx.push_back(8'h06);
      else for (int j = 3; j >= 0; j--) exp_tx.push_back(rd[8*j +: 8]);
    end else begin
      exp_len = TMO;
      exp_tx.push_back(8'h15);
    end
  endtask

  // Slave responder, host ready generator and per-cycle compare
  always @(negedge clk) begin
    if (bus.cyc_o) k++;
    else k = 0;
    bus.ack_i = bus.cyc_o && ack_lat >= 0 && k == ack_lat + 1;
    bus.dat_i = bus.ack_i ? slave_data : 32'h0;
    tx_ready  = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;

    if (!rst_i) begin
      check("stb_eq_cyc", bus.stb_o, bus.cyc_o);
      check("sel", bus.sel_o, bus.cyc_o ? 4'hf : 4'h0);
      if (bus.cyc_o) begin
        if (run == 0) cyc_starts++;
        run++;
        check("adr", bus.adr_o, exp_adr);
        check("we", bus.we_o, exp_we);
        if (exp_we) check("dat", bus.dat_o, exp_dat);
        last_adr = bus.adr_o;
        last_dat = bus.dat_o;
        last_we  = bus.we_o;
      end else begin
        if (run > 0 && exp_len >= 0) check("cyc_len", run, exp_len);
        if (run > 0) last_len = run;
        run = 0;
        check("we_idle", bus.we_o, 1'b0);
      end

      if (prev_pend) begin
        check("tx_hold_valid", tx_valid, 1'b1);
        check("tx_hold_data", tx_data, prev_data);
      end
      if (tx_valid && tx_ready) begin
        got_tx.push_back(tx_data);
        if (exp_tx.size() == 0) begin
          checks++;
          $display("FAIL tx_unexpected: got byte %0h expected none", tx_data);
        end else begin
          check("tx_byte", tx_data, exp_tx.pop_front());
        end
      end
      prev_pend = tx_valid && !tx_ready;
      prev_data = tx_data;

      if (overrun) ov_cnt++;
      if (prev_ov) check("overrun_width", overrun, 1'b0);
      prev_ov = overrun;
    end else begin
      run       = 0;
      prev_pend = 1'b0;
      prev_ov   = 1'b0;
    end
  end

  task automatic send_bytes(input logic [7:0] b[$]);
    foreach (b[i]) begin
      @(posedge clk); #1;
      rx_data  = b[i];
      rx_valid = 1'b1;
      @(posedge clk); #1;
      rx_valid = 1'b0;
    end
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_tx.size() != 0 || busy || bus.cyc_o) && n < 400);
    check({name, "_done"}, n < 400, 1'b1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_adr"}, bus.adr_o, 32'h0);
    check({tag, "_dat"}, bus.dat_o, 32'h0);
    check({tag, "_we"}, bus.we_o, 1'b0);
    check({tag, "_sel"}, bus.sel_o, 4'h0);
    check({tag, "_cyc"}, bus.cyc_o, 1'b0);
    check({tag, "_stb"}, bus.stb_o, 1'b0);
    check({tag, "_txd"}, tx_data, 8'h00);
    check({tag, "_txv"}, tx_valid, 1'b0);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_ovr"}, overrun, 1'b0);
  endtask

  initial begin
    logic [7:0] cmd[$];
    logic [7:0] pre[$];
    int ov0, cs0;

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    rst_i = 1'b0;

    // Write with ack three cycles after cyc_o
    cmd = {8'h57, 8'h00, 8'h00, 8'h10, 8'h04, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    got_tx.delete();
    model_cmd(cmd, 3, 32'h0, 1'b0);
    check("model_wr_adr", exp_adr, 32'h0000_1004);
    send_bytes(cmd);
    wait_done("wr");
    check("wr_adr", last_adr, 32'h0000_1004);
    check("wr_dat", last_dat, 32'hDEAD_BEEF);
    check("wr_we", last_we, 1'b1);
    check("wr_len", last_len, 4);
    check("wr_ntx", got_tx.size(), 1);
    if (got_tx.size() == 1) check("wr_tx", got_tx[0], 8'h06);

    // Read acked on the first cycle, host ready toggling
    cmd = {8'h52, 8'h00, 8'h00, 8'h00, 8'h08};
    got_tx.delete();
    tx_rand = 1'b1;
    model_cmd(cmd, 0, 32'h1234_5678, 1'b0);
    send_bytes(cmd);
    wait_done("rd");
    tx_rand = 1'b0;
    check("rd_len", last_len, 1);
    check("rd_we", last_we, 1'b0);
    check("rd_adr", last_adr, 32'h0000_0008);
    check("rd_ntx", got_tx.size(), 4);
    if (got_tx.size() == 4)
      check("rd_word", {got_tx[0], got_tx[1], got_tx[2], got_tx[3]}, 32'h1234_5678);

    // Read with no ack: timeout after TMO cycles
    cmd = {8'h52, 8'h00, 8'h00, 8'hFF, 8'hFC};
    got_tx.delete();
    model_cmd(cmd, -1, 32'h0, 1'b0);
    send_bytes(cmd);
    wait_done("tmo");
    check("tmo_len", last_len, 16);
    check("tmo_adr", last_adr, 32'h0000_FFFC);
    check("tmo_ntx", got_tx.size(), 1);
    if (got_tx.size() == 1) check("tmo_tx", got_tx[0], 8'h15);

    // Leading garbage ignored, unaligned address forced to word boundary
    pre = {8'h41, 8'hFF};
    cmd = {8'h41, 8'hFF, 8'h52, 8'h00, 8'h00, 8'h00, 8'h07};
    got_tx.delete();
    model_cmd(cmd, 1, 32'hA5A5_0F0F, 1'b0);
    check("model_gb_adr", exp_adr, 32'h0000_0004);
    send_bytes(pre);
    @(negedge clk);
    check("gb_idle", busy, 1'b0);
    cmd = {8'h52, 8'h00, 8'h00, 8'h00, 8'h07};
    send_bytes(cmd);
    wait_done("gb");
    check("gb_adr", last_adr, 32'h0000_0004);
    check("gb_ntx", got_tx.size(), 4);

    // Command byte arriving during BUS is dropped with an overrun pulse
    cmd = {8'h57, 8'h00, 8'h00, 8'h00, 8'h40, 8'h01, 8'h02, 8'h03, 8'h04};
    got_tx.delete();
    ov0 = ov_cnt;
    cs0 = cyc_starts;
    model_cmd(cmd, 5, 32'h0, 1'b0);
    send_bytes(cmd);
    @(posedge clk); #1;
    check("ovr_in_bus", bus.cyc_o, 1'b1);
    rx_data  = 8'h52;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    wait_done("ovr");
    repeat (10) @(negedge clk);
    check("ovr_pulses", ov_cnt - ov0, 1);
    check("ovr_no_new_cmd", cyc_starts - cs0, 1);
    check("ovr_idle", busy, 1'b0);
    check("ovr_tx", got_tx.size(), 1);

    // Reset while the bus cycle is outstanding
    cmd = {8'h52, 8'h00, 8'h00, 8'h20, 8'h00};
    model_cmd(cmd, -1, 32'h0, 1'b1);
    send_bytes(cmd);
    repeat (2) @(posedge clk);
    #1;
    check("pre_rst_cyc", bus.cyc_o, 1'b1);
    rst_i = 1'b1;
    @(posedge clk); #1;
    check_zero("midrst");
    rst_i = 1'b0;
    got_tx.delete();
    repeat (20) @(negedge clk);
    check("midrst_no_tx", got_tx.size(), 0);
    check("midrst_idle", busy, 1'b0);

    cmd = {8'h52, 8'h00, 8'h00, 8'h30, 8'h0C};
    model_cmd(cmd, 2, 32'hCAFE_F00D, 1'b0);
    send_bytes(cmd);
    wait_done("post");
    check("post_adr", last_adr, 32'h0000_300C);
    check("post_len", last_len, 3);
    check("post_ntx", got_tx.size(), 4);
    if (got_tx.size() == 4)
      check("post_word", {got_tx[0], got_tx[1], got_tx[2], got_tx[3]}, 32'hCAFE_F00D);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
